// File: rtl/xbus_arbiter.sv
// Two-master arbiter for the picoversat peripheral bus: serialises single-word
// transactions, round-robin by default, fixed master-0 priority with XARB_FIXED_PRIO_EN.
module xbus_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_sel,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_trap,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [2:0] LAT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_t            state;
  logic              last_grant;
  logic [2:0]        wait_cnt;
  logic              err_r;
  logic              pick_m1;
  logic [DATA_W-1:0] cap_rdata;

  // Writes return zero read data, so the captured word is masked here.
  assign cap_rdata = bus_we ? '0 : bus_rdata;

  always_comb begin
    pick_m1 = 1'b0;
`ifdef XARB_FIXED_PRIO_EN
    pick_m1 = m1_req && !m0_req;
`else
    if (m0_req && m1_req)
      pick_m1 = (last_grant == 1'b0);
    else
      pick_m1 = m1_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      err_r      <= 1'b0;
      grant      <= '0;
      bus_sel    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
    end else begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      bus_sel  <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant     <= pick_m1 ? 2'b10 : 2'b01;
            bus_addr  <= pick_m1 ? m1_addr : m0_addr;
            bus_we    <= pick_m1 ? m1_we : m0_we;
            bus_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            bus_sel   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          err_r <= bus_trap;
          // Writes and zero-latency reads complete straight from the select cycle.
          if (bus_we || RD_LAT == 0) begin
            if (grant[1]) begin
              m1_ack   <= 1'b1;
              m1_err   <= bus_trap;
              m1_rdata <= cap_rdata;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= bus_trap;
              m0_rdata <= cap_rdata;
            end
            state <= ACK;
          end else begin
            wait_cnt <= LAT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (grant[1]) begin
              m1_ack   <= 1'b1;
              m1_err   <= err_r;
              m1_rdata <= cap_rdata;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= err_r;
              m0_rdata <= cap_rdata;
            end
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ACK: begin
          last_grant <= grant[1];
          grant      <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed, scoreboard-driven bench for xbus_arbiter (RD_LAT=1 main instance,
// plus an RD_LAT=0 instance for the zero-latency read path).
module tb_xbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [12:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [12:0] bus_addr;
  logic        bus_sel, bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'hBAD0BAD0;
  logic        bus_trap;
  logic [1:0]  grant;
  logic [31:0] slave_data = 32'h0;

  logic        z_req, z_we;
  logic [12:0] z_addr;
  logic [31:0] z_wdata;
  logic        z_ack, z_err, z1_ack, z1_err;
  logic [31:0] z_rdata, z1_rdata;
  logic [12:0] z_bus_addr;
  logic        z_bus_sel, z_bus_we;
  logic [31:0] z_bus_wdata, z_bus_rdata;
  logic [1:0]  z_grant;
  logic [31:0] z_slave_data = 32'h0;

  typedef struct {
    logic        master;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  xbus_arbiter #(.ADDR_W(13), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_trap(bus_trap), .grant(grant)
  );

  xbus_arbiter #(.ADDR_W(13), .DATA_W(32), .RD_LAT(0)) dut_zero (
    .clk(clk), .rst(rst),
    .m0_req(z_req), .m0_addr(z_addr), .m0_we(z_we), .m0_wdata(z_wdata),
    .m0_ack(z_ack), .m0_rdata(z_rdata), .m0_err(z_err),
    .m1_req(1'b0), .m1_addr(13'h0), .m1_we(1'b0), .m1_wdata(32'h0),
    .m1_ack(z1_ack), .m1_rdata(z1_rdata), .m1_err(z1_err),
    .bus_addr(z_bus_addr), .bus_sel(z_bus_sel), .bus_we(z_bus_we), .bus_wdata(z_bus_wdata),
    .bus_rdata(z_bus_rdata), .bus_trap(1'b0), .grant(z_grant)
  );

  // Decoder model: addresses from 0x1800 up are unmapped and trap, reading as zero.
  assign bus_trap = bus_sel && (bus_addr >= 13'h1800);

  always @(posedge clk)
    bus_rdata <= bus_sel ? ((bus_addr >= 13'h1800) ? 32'h0 : slave_data) : 32'hBAD0BAD0;

  assign z_bus_rdata = z_bus_sel ? z_slave_data : 32'h0BAD0BAD;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic m, input logic [12:0] a, input logic w,
                                input logic [31:0] d);
    if (m) begin
      m1_req = 1'b1; m1_addr = a; m1_we = w; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_addr = a; m0_we = w; m0_wdata = d;
    end
  endtask

  task automatic run_txn(input string tag, input logic m, input logic [12:0] a, input logic w,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input logic [1:0] exp_grant);
    exp_t        e;
    exp_t        pe;
    int          lat = 0;
    int          sel_cnt = 0;
    logic        got = 1'b0;
    logic        ack_m = 1'b0;
    logic        both = 1'b0;
    logic [1:0]  g_first = 2'b00;
    logic [12:0] s_addr = '0;
    logic        s_we = 1'b0;
    logic [31:0] s_wdata = '0;
    e.master = m; e.rdata = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    apply_stimulus(m, a, w, d);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) g_first = grant;
      if (bus_sel) begin
        sel_cnt++; s_addr = bus_addr; s_we = bus_we; s_wdata = bus_wdata;
      end
      if (m0_ack || m1_ack) begin
        got = 1'b1; ack_m = m1_ack; both = m0_ack && m1_ack;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    if (!got) begin
      check_output({tag, "_ack_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_back());
    end else begin
      pe = sb_q.pop_front();
      check_output({tag, "_master"}, 32'(ack_m), 32'(pe.master));
      check_output({tag, "_both_ack"}, 32'(both), 32'd0);
      check_output({tag, "_rdata"}, ack_m ? m1_rdata : m0_rdata, pe.rdata);
      check_output({tag, "_err"}, 32'(ack_m ? m1_err : m0_err), 32'(pe.err));
      check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_output({tag, "_sel_cycles"}, 32'(sel_cnt), 32'd1);
      check_output({tag, "_bus_addr"}, 32'(s_addr), 32'(a));
      check_output({tag, "_bus_we"}, 32'(s_we), 32'(w));
      if (w) check_output({tag, "_bus_wdata"}, s_wdata, d);
      check_output({tag, "_grant"}, 32'(g_first), 32'(exp_grant));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t pe;
    exp_t e;
    int   n_acks;
    int   cyc;
    int   lat;
    logic got;

    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    z_req = 0; z_we = 0; z_addr = '0; z_wdata = '0;
    repeat (3) @(negedge clk);

    check_output("rst_m0_ack", 32'(m0_ack), 32'd0);
    check_output("rst_m1_ack", 32'(m1_ack), 32'd0);
    check_output("rst_bus_sel", 32'(bus_sel), 32'd0);
    check_output("rst_grant", 32'(grant), 32'd0);
    check_output("rst_bus_addr", 32'(bus_addr), 32'd0);
    check_output("rst_bus_we", 32'(bus_we), 32'd0);
    check_output("rst_m0_rdata", m0_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn("m0_write", 1'b0, 13'h100, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 2, 2'b01);

    slave_data = 32'h0000_0001;
    run_txn("m1_read", 1'b1, 13'h040, 1'b0, 32'h0, 32'h1, 1'b0, 3, 2'b10);

    slave_data = 32'h5A5A_1234;
    run_txn("m0_trap", 1'b0, 13'h1F00, 1'b0, 32'h0, 32'h0, 1'b1, 3, 2'b01);

    run_txn("m0_read", 1'b0, 13'h0A0, 1'b0, 32'h0, 32'h5A5A_1234, 1'b0, 3, 2'b01);

    // Fairness: both masters hold their request across six transactions.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef XARB_FIXED_PRIO_EN
      e.master = 1'b0;
`else
      e.master = i[0];
`endif
      e.rdata = 32'h0; e.err = 1'b0;
      sb_q.push_back(e);
    end
    apply_stimulus(1'b0, 13'h200, 1'b1, 32'h1111_0000);
    apply_stimulus(1'b1, 13'h300, 1'b1, 32'h2222_0000);
    n_acks = 0;
    cyc = 0;
    while (n_acks < 6 && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (m0_ack || m1_ack) begin
        pe = sb_q.pop_front();
        check_output($sformatf("fair%0d_master", n_acks), 32'(m1_ack), 32'(pe.master));
        n_acks++;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check_output("fair_ack_count", 32'(n_acks), 32'd6);
    sb_q.delete();
    @(negedge clk);

    // Reset while an m1 read sits in WAIT.
    apply_stimulus(1'b1, 13'h044, 1'b0, 32'h0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_output("abort_pre_grant", 32'(grant), 32'(2'b10));
    check_output("abort_pre_sel", 32'(bus_sel), 32'd0);
    rst = 1'b1;
    m1_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("abort_m1_ack", 32'(m1_ack), 32'd0);
    check_output("abort_bus_sel", 32'(bus_sel), 32'd0);
    check_output("abort_grant", 32'(grant), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("abort_m1_ack_later", 32'(m1_ack), 32'd0);

    slave_data = 32'h0BEE_F00D;
    run_txn("post_abort", 1'b0, 13'h080, 1'b0, 32'h0, 32'h0BEE_F00D, 1'b0, 3, 2'b01);

    // Zero-latency read path.
    z_slave_data = 32'hCAFE0000;
    z_req = 1'b1; z_addr = 13'h010; z_we = 1'b0; z_wdata = 32'h0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (z_ack) got = 1'b1;
    end
    z_req = 1'b0;
    check_output("rdlat0_ack_seen", 32'(got), 32'd1);
    check_output("rdlat0_latency", 32'(lat), 32'd2);
    check_output("rdlat0_rdata", z_rdata, 32'hCAFE0000);
    check_output("rdlat0_m1_ack", 32'(z1_ack), 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
